d2d_link_rx: RTL
================

// Module: d2d_link_rx
// PURPOSE
// - Receive end of the die-to-die link: takes byte-wide flits from the link, reassembles {addr,data} packets, buffers them and presents them on the dstData/dstAddr/dstValid/dstReady interface.
// - Credit-based flow control toward the link transmitter; one credit equals one packet buffer entry.
// - Sits between the link PHY-side wires and the destination-die consumer.
// PARAMETERS
// - DATA_W  32  payload data width, multiple of 8
// - ADDR_W  16  payload address width, multiple of 8
// - DEPTH    4  packet buffer entries, power of 2, >= 2; transmitter starts with DEPTH credits
// PORTS
// - clk             in   1        single clock, all logic rising-edge
// - rst             in   1        synchronous reset, active-high
// - linkValid       in   1        flit present on linkData this cycle (no backpressure on link)
// - linkSof         in   1        qualifies first flit of a packet
// - linkData        in   8        flit byte
// - linkCreditRet   out  2        credits returned this cycle (0..2)
// - dstData         out  DATA_W   head packet data
// - dstAddr         out  ADDR_W   head packet address
// - dstValid        out  1        head entry valid
// - dstReady        in   1        consumer accepts head when dstValid & dstReady
// - errSticky       out  3        {overflow, framing, parity}; sticky until rst
// BEHAVIOUR
// - Reset: linkCreditRet=0, dstValid=0, dstData=0, dstAddr=0, errSticky=0, FIFO empty, FSM IDLE, flit counter 0.
// - Packet format: ADDR_W/8 address bytes then DATA_W/8 data bytes, MSB byte first; default 6 flits. Optional parity flit appended (see CONFIGURATION).
// - Flits accepted only when linkValid=1; gaps of any length allowed between flits.
// - FSM: IDLE -(linkValid&linkSof)-> ADDR -(last addr byte)-> DATA -(last data byte)-> COMMIT (or PAR when parity enabled) -> IDLE.
// - COMMIT is a single cycle: writes assembled packet to FIFO; a flit with linkSof in COMMIT starts the next packet (back-to-back packets at full rate).
// - IDLE: linkValid without linkSof ignored, framing error set.
// - linkSof while in ADDR/DATA/PAR: current packet discarded, framing error set, credit returned, new packet starts with this flit.
// - FIFO first-word-fall-through: packet written in COMMIT cycle N is visible with dstValid=1 in cycle N+1 if FIFO was empty.
// - dstData/dstAddr/dstValid held stable while dstValid & !dstReady.
// - Pop on dstValid & dstReady: one credit returned next cycle.
// - Write and pop in same cycle: both performed; count unchanged; legal when full.
// - Commit while FIFO full and no pop: packet dropped, overflow error set, no credit returned (protocol violation by transmitter).
// - Discarded/parity-failed packets return their credit; linkCreditRet = pops + discards in that cycle (max 2).
// - Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1 to distinguish full/empty.
// - rst asserted mid-packet or with FIFO occupied: all contents dropped, no credits returned; transmitter must also reset to DEPTH credits.
// CONFIGURATION
// - D2D_RX_PARITY_EN defined: one extra flit after data = XOR of all address and data bytes; PAR state checks it; mismatch -> packet discarded, parity error set, credit returned; match -> COMMIT.
// - D2D_RX_PARITY_EN undefined: no PAR state, DATA -> COMMIT directly, errSticky[0] tied 0.
// TESTING
// - Reset then flits 00 01 A5 A5 A5 A5 (sof on first) -> dstValid next cycle after COMMIT, dstAddr=0001, dstData=A5A5A5A5; pop -> linkCreditRet=1 one cycle.
// - dstReady=0, send DEPTH packets back-to-back -> all buffered, outputs hold first packet; 5th packet -> overflow bit set, FIFO unchanged.
// - dstReady=1, continuous full-rate packets with random linkValid gaps -> all packets delivered in order, credits returned 1:1.
// - linkSof mid-DATA after 3 flits -> framing bit set, linkCreditRet=1, new packet from that flit delivered correctly.
// - Parity build: wrong parity byte (e.g. 0x00 for 0001/A5A5A5A5, correct 0x01) -> no dstValid, parity bit set, linkCreditRet=1.
// - rst asserted with 2 entries queued and packet half-received -> next cycle dstValid=0, errSticky=0, linkCreditRet=0.

Source files
------------

// File: rtl/d2d_link_rx.sv
// d2d_link_rx: receive end of the die-to-die link.
// Reassembles byte-wide flits into {addr,data} packets and buffers them in a
// first-word-fall-through FIFO. Credits are returned to the link transmitter
// as buffer entries free up or as packets are discarded.
// Optional feature macro: D2D_RX_PARITY_EN adds a trailing XOR parity flit
// that is checked before a packet is committed.
module d2d_link_rx #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              linkValid,
  input  logic              linkSof,
  input  logic [7:0]        linkData,
  output logic [1:0]        linkCreditRet,
  output logic [DATA_W-1:0] dstData,
  output logic [ADDR_W-1:0] dstAddr,
  output logic              dstValid,
  input  logic              dstReady,
  output logic [2:0]        errSticky
);

  localparam int ADDR_B = ADDR_W / 8;
  localparam int DATA_B = DATA_W / 8;
  localparam int NFLIT  = ADDR_B + DATA_B;
  localparam int PKT_W  = ADDR_W + DATA_W;
  localparam int CNT_W  = $clog2(NFLIT + 1);
  localparam int PTR_W  = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_B);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NFLIT);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

`ifdef D2D_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, ADDR, DATA, PAR, COMMIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADDR, DATA, COMMIT} state_t;
`endif

  // state after the first flit of a packet has been taken
  localparam state_t FIRST_STATE = (ADDR_B > 1) ? ADDR : DATA;

  state_t           state, stateNext;
  logic [CNT_W-1:0] flitCnt, cntNext;
  logic             startPkt, shiftFlit, discard, framErr, parErr, commit;
  logic [PKT_W-1:0] asmPkt;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W:0]   count;
  logic             full, doPop, doWrite, overflow;
  logic [PKT_W-1:0] headPkt;

`ifdef D2D_RX_PARITY_EN
  logic [7:0] parAcc;
`endif

  // Sum of per-cycle credit sources; at most two so it always fits in 2 bits
  function automatic logic [1:0] creditSum(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Assembly FSM state and flit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      flitCnt <= '0;
    end else begin
      state   <= stateNext;
      flitCnt <= cntNext;
    end
  end

  // Next-state decode: packet start, byte shifting, discard and error flags
  always_comb begin
    stateNext = state;
    cntNext   = flitCnt;
    startPkt  = 1'b0;
    shiftFlit = 1'b0;
    discard   = 1'b0;
    framErr   = 1'b0;
    parErr    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (linkValid) begin
          if (linkSof) startPkt = 1'b1;
          else         framErr  = 1'b1;
        end
      end
      ADDR, DATA: begin
        if (linkValid) begin
          if (linkSof) begin
            // a new packet aborts the one in flight; its buffer credit goes back
            startPkt = 1'b1;
            discard  = 1'b1;
            framErr  = 1'b1;
          end else begin
            shiftFlit = 1'b1;
          end
        end
      end
`ifdef D2D_RX_PARITY_EN
      PAR: begin
        if (linkValid) begin
          if (linkSof) begin
            startPkt = 1'b1;
            discard  = 1'b1;
            framErr  = 1'b1;
          end else if (linkData == parAcc) begin
            stateNext = COMMIT;
          end else begin
            discard   = 1'b1;
            parErr    = 1'b1;
            stateNext = IDLE;
            cntNext   = '0;
          end
        end
      end
`endif
      COMMIT: begin
        commit    = 1'b1;
        stateNext = IDLE;
        cntNext   = '0;
        if (linkValid) begin
          if (linkSof) startPkt = 1'b1;
          else         framErr  = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase

    if (shiftFlit) begin
      cntNext = flitCnt + CNT_ONE;
      if (cntNext == CNT_LAST) begin
`ifdef D2D_RX_PARITY_EN
        stateNext = PAR;
`else
        stateNext = COMMIT;
`endif
      end else if (cntNext >= CNT_ADDR) begin
        stateNext = DATA;
      end else begin
        stateNext = ADDR;
      end
    end

    if (startPkt) begin
      cntNext   = CNT_ONE;
      stateNext = FIRST_STATE;
    end
  end

  // Packet assembly: MSB byte first, address bytes land in the upper bits
  always_ff @(posedge clk) begin
    if (startPkt)       asmPkt <= PKT_W'(linkData);
    else if (shiftFlit) asmPkt <= {asmPkt[PKT_W-9:0], linkData};
  end

`ifdef D2D_RX_PARITY_EN
  // Running XOR over address and data bytes for the trailing parity flit
  always_ff @(posedge clk) begin
    if (startPkt)       parAcc <= linkData;
    else if (shiftFlit) parAcc <= parAcc ^ linkData;
  end
`endif

  assign full     = (count == CNT_FULL);
  assign dstValid = (count != '0);
  assign doPop    = dstValid & dstReady;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign doWrite  = commit & (~full | doPop);
  assign overflow = commit & full & ~doPop;
  assign headPkt  = mem[rdPtr];
  assign dstAddr  = dstValid ? headPkt[PKT_W-1 -: ADDR_W] : '0;
  assign dstData  = dstValid ? headPkt[DATA_W-1:0]        : '0;

  // Packet buffer storage
  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= asmPkt;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doPop)   rdPtr <= rdPtr + 1'b1;
      case ({doWrite, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Credit return and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      linkCreditRet <= '0;
      errSticky     <= '0;
    end else begin
      linkCreditRet <= creditSum(doPop, discard);
      errSticky     <= errSticky | {overflow, framErr, parErr};
    end
  end

endmodule
